// File: rtl/mips_pkg.sv
// Shared types and instruction field positions for the MIPS core.
// The fetch unit and its next-PC helper both import this package.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int TGT_MSB   = 25;
  localparam int TGT_LSB   = 0;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Branch offset: sign-extended immediate, scaled to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_pc_next.sv
// Combinational next-PC selection: sequential, taken branch or J-type jump.
// Jump takes priority over a taken branch; all sums wrap modulo 2^32.
module pc_next
  import mips_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  input  logic        i_pcsrc,
  input  logic        i_jump,
  output logic [31:0] o_pcplus4,
  output logic [31:0] o_pc_next
);

  logic [31:0] w_pcplus4;
  logic [31:0] w_pc_branch;
  logic [31:0] w_pc_jump;

  assign w_pcplus4   = i_pc + 32'd4;
  assign w_pc_branch = w_pcplus4 + branch_offset(i_imm);
  assign w_pc_jump   = {w_pcplus4[31:28], i_target, 2'b00};

  always_comb begin
    o_pc_next = w_pcplus4;
    if (i_jump) begin
      o_pc_next = w_pc_jump;
    end else if (i_pcsrc) begin
      o_pc_next = w_pc_branch;
    end
  end

  assign o_pcplus4 = w_pcplus4;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the PC, issues one valid/ready fetch at a time
// and holds the returned word in the instruction register until acknowledged.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | one cycle after reset, no request
// REQ   | request pending at pc, held until imem_req_ready
// WAIT  | request accepted, waiting for imem_rsp_valid
// HOLD  | instr valid, waiting for instr_ack to step the PC
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  input  logic        instr_ack,
  input  logic        pcsrc,
  input  logic        jump,
  output logic [31:0] pc,
  output logic [31:0] pcplus4
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic         r_req_valid;
  logic         r_instr_valid;

  logic [31:0]  w_pcplus4;
  logic [31:0]  w_pc_next;

  pc_next u_pc_next (
    .i_pc      (r_pc),
    .i_imm     (r_instr[IMM_MSB:IMM_LSB]),
    .i_target  (r_instr[TGT_MSB:TGT_LSB]),
    .i_pcsrc   (pcsrc),
    .i_jump    (jump),
    .o_pcplus4 (w_pcplus4),
    .o_pc_next (w_pc_next)
  );

  // Responses, acks and branch controls only matter in their own state,
  // so a stray handshake elsewhere cannot disturb the PC or instr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC_ALIGNED;
      r_instr       <= '0;
      r_req_valid   <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state     <= REQ;
          r_req_valid <= 1'b1;
        end
        REQ: begin
          if (imem_req_ready) begin
            r_state     <= WAIT;
            r_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            r_state       <= HOLD;
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_ack) begin
            r_state       <= REQ;
            r_pc          <= w_pc_next;
            r_instr_valid <= 1'b0;
            r_req_valid   <= 1'b1;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_req_valid   <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_addr      = r_pc;
  assign pc             = r_pc;
  assign pcplus4        = w_pcplus4;
  assign instr          = r_instr;
  assign instr_valid    = r_instr_valid;
  assign op             = r_instr[OP_MSB:OP_LSB];
  assign funct          = r_instr[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a main instance at PC 0 and a second one
// reset to an unaligned PC just below 0x8000_0000, both driven by the same inputs.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_ack = 1'b0;
  logic        pcsrc = 1'b0;
  logic        jump = 1'b0;

  logic        imem_req_valid, instr_valid;
  logic [31:0] imem_addr, instr, pc, pcplus4;
  logic [5:0]  op, funct;

  logic        d2_req_valid, d2_instr_valid;
  logic [31:0] d2_addr, d2_instr, d2_pc, d2_pcplus4;
  logic [5:0]  d2_op, d2_funct;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_req = 0;
  int last_ack = 0;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .op(op), .funct(funct),
    .instr_ack(instr_ack), .pcsrc(pcsrc), .jump(jump),
    .pc(pc), .pcplus4(pcplus4)
  );

  ifetch_unit #(.RESET_PC(32'h7FFF_FFFB)) dut2 (
    .clk(clk), .reset(reset),
    .imem_req_valid(d2_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(d2_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .instr(d2_instr), .instr_valid(d2_instr_valid), .op(d2_op), .funct(d2_funct),
    .instr_ack(instr_ack), .pcsrc(pcsrc), .jump(jump),
    .pc(d2_pc), .pcplus4(d2_pcplus4)
  );

  always @(posedge clk) begin
    cyc++;
    if (reset && imem_req_valid && imem_req_ready) n_req++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full fetch: optional request stall, response delay and ack delay.
  // Stray rsp_valid in REQ, ack in WAIT and pcsrc/jump in HOLD must be ignored.
  task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] word,
                           input logic [31:0] exp_next, input int rdy_dly,
                           input int rsp_dly, input int ack_dly,
                           input logic br, input logic jmp);
    int guard;
    guard = 0;
    while (!imem_req_valid && guard < 10) begin
      step();
      guard++;
    end
    check("req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("req_addr", imem_addr, exp_addr);
    imem_rsp_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < rdy_dly; i++) begin
      step();
      check("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
      check("req_hold_addr", imem_addr, exp_addr);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    check("wait_req_low", {31'b0, imem_req_valid}, 32'd0);
    check("wait_no_instr", {31'b0, instr_valid}, 32'd0);
    instr_ack = 1'b1;
    for (int i = 0; i < rsp_dly; i++) begin
      step();
      check("wait_stall_valid", {31'b0, instr_valid}, 32'd0);
      check("wait_stall_addr", imem_addr, exp_addr);
    end
    instr_ack = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rdata = word;
    step();
    imem_rsp_valid = 1'b0;
    imem_rdata = ~word;
    check("hold_valid", {31'b0, instr_valid}, 32'd1);
    check("hold_instr", instr, word);
    check("hold_op", {26'b0, op}, {26'b0, word[31:26]});
    check("hold_funct", {26'b0, funct}, {26'b0, word[5:0]});
    pcsrc = 1'b1;
    jump = 1'b1;
    for (int i = 0; i < ack_dly; i++) begin
      step();
      check("hold_stall_instr", instr, word);
      check("hold_stall_valid", {31'b0, instr_valid}, 32'd1);
      check("hold_stall_pc", imem_addr, exp_addr);
    end
    instr_ack = 1'b1;
    pcsrc = br;
    jump = jmp;
    step();
    instr_ack = 1'b0;
    pcsrc = 1'b0;
    jump = 1'b0;
    last_ack = cyc;
    check("ack_valid_drop", {31'b0, instr_valid}, 32'd0);
    check("ack_next_req", {31'b0, imem_req_valid}, 32'd1);
    check("next_pc", imem_addr, exp_next);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, t3;
    repeat (3) step();
    check("rst_pc", pc, 32'h0);
    check("rst_pcplus4", pcplus4, 32'h4);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_op_funct", {20'b0, op, funct}, 32'h0);
    check("rst2_pc_aligned", d2_pc, 32'h7FFF_FFF8);
    check("rst2_pcplus4", d2_pcplus4, 32'h7FFF_FFFC);

    reset = 1'b1;
    check("idle_no_req", {31'b0, imem_req_valid}, 32'd0);
    step();
    check("first_req", {31'b0, imem_req_valid}, 32'd1);

    fetch_one(32'h0, 32'h0000_0020, 32'h4, 0, 0, 0, 1'b0, 1'b0);
    t1 = last_ack;
    fetch_one(32'h4, 32'h2002_0005, 32'h8, 0, 0, 0, 1'b0, 1'b0);
    t2 = last_ack;
    check("d2_pc_seq", d2_pc, 32'h8000_0000);
    fetch_one(32'h8, 32'h0800_0010, 32'h40, 0, 0, 0, 1'b1, 1'b1);
    t3 = last_ack;
    check("throughput_a", t2 - t1, 32'd3);
    check("throughput_b", t3 - t2, 32'd3);
    check("d2_jump_prio", d2_pc, 32'h8000_0040);

    fetch_one(32'h40, 32'h1000_FFFF, 32'h40, 4, 3, 5, 1'b1, 1'b0);
    fetch_one(32'h40, 32'h1000_FFFF, 32'h44, 0, 0, 0, 1'b0, 1'b0);
    fetch_one(32'h44, 32'h1000_FFED, 32'hFFFF_FFFC, 0, 0, 0, 1'b1, 1'b0);
    check("pcplus4_wrap", pcplus4, 32'h0);
    fetch_one(32'hFFFF_FFFC, 32'h0000_0020, 32'h0, 0, 0, 0, 1'b0, 1'b0);
    fetch_one(32'h0, 32'h0000_0020, 32'h4, 0, 0, 0, 1'b0, 1'b0);

    // Abandon a fetch in WAIT, then offer stray responses in IDLE and REQ.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("mid_wait", {31'b0, imem_req_valid}, 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    check("mid_rst_req", {31'b0, imem_req_valid}, 32'd0);
    check("mid_rst_pc", imem_addr, 32'h0);
    check("mid_rst_instr", instr, 32'h0);
    step();
    step();
    imem_rsp_valid = 1'b1;
    imem_rdata = 32'h1234_5678;
    reset = 1'b1;
    step();
    check("post_rst_req", {31'b0, imem_req_valid}, 32'd1);
    check("post_rst_ign_idle", {31'b0, instr_valid}, 32'd0);
    step();
    check("post_rst_ign_req", {31'b0, instr_valid}, 32'd0);
    check("post_rst_instr", instr, 32'h0);
    check("post_rst_addr", imem_addr, 32'h0);
    imem_rsp_valid = 1'b0;
    fetch_one(32'h0, 32'h0000_0020, 32'h4, 0, 0, 0, 1'b0, 1'b0);

    check("req_count", n_req, 32'd10);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit for the MIPS core. It owns the program counter, fetches one instruction at a time over a valid/ready instruction-memory port, and holds the result in an instruction register. That register supplies `op` and `funct` to the controller. After the datapath acknowledges an instruction, the unit steps the PC to the next address using the controller's `pcsrc` and `jump` outputs.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset. Bits [1:0] are forced to 0.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `imem_req_valid`  out  1  fetch request pending.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_addr`  out  32  fetch byte address; always equals `pc`.
- `imem_rsp_valid`  in  1  `imem_rdata` is valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  instruction register contents.
- `instr_valid`  out  1  `instr`, `op` and `funct` hold a fetched instruction.
- `op`  out  6  `instr[31:26]`.
- `funct`  out  6  `instr[5:0]`.
- `instr_ack`  in  1  datapath retires the current instruction this cycle.
- `pcsrc`  in  1  branch taken (`branch & zero`); sampled only on an ack.
- `jump`  in  1  J-type jump; sampled only on an ack.
- `pc`  out  32  address of the current or pending instruction.
- `pcplus4`  out  32  `pc + 4`, modulo 2^32.

## Operation
States:
- IDLE
  - Entered on reset.
  - Always goes to REQ on the next edge.
- REQ
  - `imem_req_valid=1`, `imem_addr=pc`.
  - On `imem_req_ready=1`, goes to WAIT.
  - Otherwise stays in REQ; `imem_req_valid` and `imem_addr` are held stable.
- WAIT
  - `imem_req_valid=0`.
  - On `imem_rsp_valid=1`, captures `imem_rdata` into `instr` and goes to HOLD.
- HOLD
  - `instr_valid=1`.
  - On `instr_ack=1`, loads the next PC and goes to REQ.
  - `instr` is held stable until the ack.

Next-PC rule, evaluated on the ack edge only:
- If `jump` = 1: `{pcplus4[31:28], instr[25:0], 2'b00}`. `jump` has priority over `pcsrc`.
- Else if `pcsrc` = 1: `pcplus4 + ({{14{instr[15]}}, instr[15:0], 2'b00})`.
- Else: `pcplus4`.

All PC arithmetic is 32-bit and wraps silently (0xFFFF_FFFC + 4 = 0).

Boundary rules:
- `imem_rsp_valid` is ignored outside WAIT.
- A response in the same cycle as request acceptance is not legal and is ignored.
- `instr_ack` is ignored outside HOLD.
- `pcsrc` and `jump` are ignored except in a HOLD cycle with `instr_ack=1`.
- Reset asserted mid-fetch abandons the transaction immediately. The memory shares this reset, so no stale response survives it.

## Timing
Reset values:
- `pc = imem_addr = RESET_PC`
- `pcplus4 = RESET_PC + 4`
- `imem_req_valid = 0`
- `instr_valid = 0`
- `instr`, `op`, `funct` = 0

Cycle timing:
- First request: `imem_req_valid` rises in the second cycle after reset deasserts (one IDLE cycle).
- Minimum latency: `instr_valid` rises 2 cycles after the REQ cycle in which `imem_req_ready=1`, given a response in the next cycle.
- Minimum throughput: one instruction per 3 cycles (REQ, WAIT, HOLD with immediate ack).
- `instr_valid` falls in the cycle after an ack.
- `pc` updates on the ack edge, so it is visible on `imem_addr` in the following REQ cycle.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.

## Structure
- Package `mips_pkg` holds:
  - the `fetch_state_t` enum (IDLE, REQ, WAIT, HOLD);
  - field-position constants for op [31:26], funct [5:0], imm [15:0] and target [25:0];
  - `RESET_PC_DEFAULT`.
- One combinational sub-module, `pc_next`, computes `pcplus4` and the next-PC mux from `pc`, `instr`, `pcsrc` and `jump`.

## Test plan
- **Reset and straight-line fetch.**
  - Stimulus: `RESET_PC=0`, memory always ready, 1-cycle response, immediate ack, no branches.
  - Required: addresses 0x0, 0x4, 0x8; one instruction every 3 cycles; `imem_req_valid=0` during reset.
- **Taken branch.**
  - Stimulus: `instr=0x1000_FFFF` (beq, imm=-1) at pc 0x40; ack with `pcsrc=1`.
  - Required: next fetch address 0x40. With `pcsrc=0`, next fetch address 0x44.
- **Jump priority.**
  - Stimulus: `instr=0x0800_0010` at pc 0x8000_0000; ack with `jump=1` and `pcsrc=1`.
  - Required: next fetch address 0x8000_0040.
- **Backpressure and stalls.**
  - Stimulus: `imem_req_ready=0` for 4 cycles, response delayed 3 cycles, ack delayed 5 cycles.
  - Required: `imem_addr` and `instr` stable throughout; exactly one request issued per instruction.
- **Wrap-around.**
  - Stimulus: `RESET_PC=0xFFFF_FFFC`, ack with no branch.
  - Required: next fetch address 0x0.
- **Reset mid-operation.**
  - Stimulus: assert `reset=0` while in WAIT; drive `imem_rsp_valid` during IDLE and during REQ after reset release.
  - Required: responses ignored; `instr_valid=0`; first request to `RESET_PC`.
